instr_fetch: RTL and testbench

Instruction fetch front-end for the cpu16 core.
- Acts as the reading end of the combinational program memory: drives a word address and captures the returned 16-bit instruction in the same cycle.
- Buffers fetched words with their PCs in a small prefetch FIFO.
- Hands them to decode over a valid/ready handshake.
- Supports branch/jump redirect with flush, and a fetch-enable for halt.

---
 rtl/cpu16_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/instr_fetch.sv | 82 ++++++++
 tb/tb_instr_fetch.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cpu16_pkg.sv
// Shared types and constants for the cpu16 core.
//   word_t        : 16-bit instruction/data word
//   addr_t        : 16-bit word address
//   RESET_VECTOR  : fetch address after reset
//   fetch_entry_t : one prefetch slot, the fetched word plus the PC it came from
package cpu16_pkg;

  typedef logic [15:0] word_t;
  typedef logic [15:0] addr_t;

  localparam addr_t RESET_VECTOR = 16'h0000;

  typedef struct packed {
    addr_t pc;
    word_t instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch_entry_t.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears pointers and storage)
//   push       : write wdata at the tail (legal when full if pop is also high)
//   pop        : drop the head entry (caller guarantees !empty)
//   flush      : discard all entries; overrides push/pop
//   wdata      : entry to write
//   full/empty : occupancy flags
//   head       : entry at the read pointer, straight from storage
module fetch_fifo
  import cpu16_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_entry_t   storage [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  count;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      // NOTE: storage is reset on purpose so instr/instr_pc read 0 after
      // reset; a FIFO that does not need that should leave memories unreset.
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else if (flush) begin
      // Storage contents are left in place; only occupancy is discarded.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        storage[wr_ptr] <= wdata;
        // DEPTH is a power of two, so natural pointer overflow is modulo DEPTH.
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign head  = storage[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front-end for cpu16.
// Reads a combinational program memory at fetch_pc, buffers {pc, word} in a
// prefetch FIFO and presents the head to decode over valid/ready.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   mem_addr        : word address to program memory (= fetch_pc, registered)
//   mem_data        : word at mem_addr, same cycle
//   fetch_en        : 1 = fetch, 0 = hold fetch_pc and stop pushing
//   redirect_valid  : flush and restart fetch at redirect_pc
//   redirect_pc     : new fetch address
//   instr_valid     : head entry valid
//   instr_ready     : decode accepts the head
//   instr, instr_pc : head word and the address it was fetched from
module instr_fetch
  import cpu16_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic [15:0] instr_pc
);

  addr_t        fetch_pc;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  fetch_entry_t wdata;
  fetch_entry_t head;

  assign instr_valid = !empty;
  assign pop         = instr_valid && instr_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle,
  // which is what keeps a ready decode fed without bubbles.
  assign push        = fetch_en && !redirect_valid && (!full || pop);

  assign wdata.pc    = fetch_pc;
  assign wdata.instr = mem_data;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
    end else if (push) begin
      fetch_pc <= fetch_pc + 16'd1;
    end
  end

  // Flush on redirect: a head popped the same cycle is already delivered,
  // everything else behind it is dropped.
  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wdata),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign mem_addr = fetch_pc;
  assign instr    = head.instr;
  assign instr_pc = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. Program memory model: word = addr ^ 16'hA5A5.
// Inputs change and outputs are sampled on the falling edge.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr;
  logic [15:0] instr_pc;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign mem_data = mem_addr ^ 16'hA5A5;

  instr_fetch #(
    .DEPTH    (4),
    .RESET_PC (16'h0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  // One reset edge, then release with the given fetch_en / instr_ready.
  task automatic reset_and_release(input logic en, input logic rdy);
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    fetch_en = en;
    instr_ready = rdy;
  endtask

  task automatic test_reset;
    reset_and_release(1'b1, 1'b1);
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    vectors++; if (instr !== 16'h0000) begin miscompares++; $display("FAIL reset_instr: got %h want 0000", instr); end
    vectors++; if (instr_pc !== 16'h0000) begin miscompares++; $display("FAIL reset_pc: got %h want 0000", instr_pc); end
    vectors++; if (mem_addr !== 16'h0000) begin miscompares++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
  endtask

  // Continues straight from test_reset: fetch_en=1, instr_ready=1.
  task automatic test_stream;
    logic [15:0] epc;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      epc = 16'(k);
      vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d]: got %b want 1", k, instr_valid); end
      vectors++; if (instr_pc !== epc) begin miscompares++; $display("FAIL stream_pc[%0d]: got %h want %h", k, instr_pc, epc); end
      vectors++; if (instr !== (epc ^ 16'hA5A5)) begin miscompares++; $display("FAIL stream_instr[%0d]: got %h want %h", k, instr, epc ^ 16'hA5A5); end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] epc;
    reset_and_release(1'b1, 1'b0);
    repeat (10) @(negedge clk);
    vectors++; if (mem_addr !== 16'h0004) begin miscompares++; $display("FAIL bp_mem_addr_hold: got %h want 0004", mem_addr); end
    vectors++; if (instr_pc !== 16'h0000) begin miscompares++; $display("FAIL bp_head_hold: got %h want 0000", instr_pc); end
    vectors++; if (instr !== 16'hA5A5) begin miscompares++; $display("FAIL bp_instr_hold: got %h want A5A5", instr); end
    instr_ready = 1'b1;
    // Head 0000 is visible now; 0001..0004 follow one per cycle.
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      epc = 16'(k);
      vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid[%0d]: got %b want 1", k, instr_valid); end
      vectors++; if (instr_pc !== epc) begin miscompares++; $display("FAIL bp_pc[%0d]: got %h want %h", k, instr_pc, epc); end
    end
  endtask

  task automatic test_redirect;
    reset_and_release(1'b1, 1'b0);
    repeat (3) @(negedge clk);  // three entries buffered
    vectors++; if (mem_addr !== 16'h0003) begin miscompares++; $display("FAIL rd_pre_mem_addr: got %h want 0003", mem_addr); end
    redirect_valid = 1'b1;
    redirect_pc = 16'h0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rd_flush_valid: got %b want 0", instr_valid); end
    vectors++; if (mem_addr !== 16'h0100) begin miscompares++; $display("FAIL rd_mem_addr: got %h want 0100", mem_addr); end
    instr_ready = 1'b1;
    @(negedge clk);
    vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL rd_valid: got %b want 1", instr_valid); end
    vectors++; if (instr_pc !== 16'h0100) begin miscompares++; $display("FAIL rd_pc: got %h want 0100", instr_pc); end
    vectors++; if (instr !== 16'hA4A5) begin miscompares++; $display("FAIL rd_instr: got %h want A4A5", instr); end
    @(negedge clk);
    vectors++; if (instr_pc !== 16'h0101) begin miscompares++; $display("FAIL rd_next_pc: got %h want 0101", instr_pc); end
    vectors++; if (instr !== 16'hA4A4) begin miscompares++; $display("FAIL rd_next_instr: got %h want A4A4", instr); end
  endtask

  task automatic test_wrap;
    logic [15:0] epc [3];
    logic [15:0] ewd [3];
    epc = '{16'hFFFE, 16'hFFFF, 16'h0000};
    ewd = '{16'h5A5B, 16'h5A5A, 16'hA5A5};
    fetch_en = 1'b1;
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFE;
    @(negedge clk);
    redirect_valid = 1'b0;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_flush_valid: got %b want 0", instr_valid); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++; if (instr_pc !== epc[k]) begin miscompares++; $display("FAIL wrap_pc[%0d]: got %h want %h", k, instr_pc, epc[k]); end
      vectors++; if (instr !== ewd[k]) begin miscompares++; $display("FAIL wrap_instr[%0d]: got %h want %h", k, instr, ewd[k]); end
    end
  endtask

  task automatic test_reset_midstream;
    instr_ready = 1'b0;
    repeat (6) @(negedge clk);  // FIFO full
    vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL mr_full_valid: got %b want 1", instr_valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    instr_ready = 1'b1;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL mr_valid: got %b want 0", instr_valid); end
    vectors++; if (mem_addr !== 16'h0000) begin miscompares++; $display("FAIL mr_mem_addr: got %h want 0000", mem_addr); end
    @(negedge clk);
    vectors++; if (instr_pc !== 16'h0000) begin miscompares++; $display("FAIL mr_pc0: got %h want 0000", instr_pc); end
    @(negedge clk);
    vectors++; if (instr_pc !== 16'h0001) begin miscompares++; $display("FAIL mr_pc1: got %h want 0001", instr_pc); end
  endtask

  task automatic test_halt;
    reset_and_release(1'b1, 1'b0);
    repeat (2) @(negedge clk);  // two entries, mem_addr=0002
    fetch_en = 1'b0;
    instr_ready = 1'b1;
    vectors++; if (instr_pc !== 16'h0000) begin miscompares++; $display("FAIL halt_pc0: got %h want 0000", instr_pc); end
    @(negedge clk);
    vectors++; if (instr_pc !== 16'h0001) begin miscompares++; $display("FAIL halt_pc1: got %h want 0001", instr_pc); end
    vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL halt_valid1: got %b want 1", instr_valid); end
    repeat (2) begin
      @(negedge clk);
      vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL halt_drained: got %b want 0", instr_valid); end
      vectors++; if (mem_addr !== 16'h0002) begin miscompares++; $display("FAIL halt_mem_addr: got %h want 0002", mem_addr); end
    end
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    @(negedge clk);
    redirect_valid = 1'b0;
    vectors++; if (mem_addr !== 16'h0040) begin miscompares++; $display("FAIL halt_rd_mem_addr: got %h want 0040", mem_addr); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL halt_rd_valid: got %b want 0", instr_valid); end
    fetch_en = 1'b1;
    @(negedge clk);
    vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL halt_resume_valid: got %b want 1", instr_valid); end
    vectors++; if (instr_pc !== 16'h0040) begin miscompares++; $display("FAIL halt_resume_pc: got %h want 0040", instr_pc); end
    vectors++; if (instr !== 16'hA5E5) begin miscompares++; $display("FAIL halt_resume_instr: got %h want A5E5", instr); end
  endtask

  task automatic test_redirect_vs_reset;
    fetch_en = 1'b1;
    instr_ready = 1'b1;
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0200;
    @(negedge clk);
    rst = 1'b0;
    redirect_valid = 1'b0;
    vectors++; if (mem_addr !== 16'h0000) begin miscompares++; $display("FAIL rst_wins_mem_addr: got %h want 0000", mem_addr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_midstream();
    test_halt();
    test_redirect_vs_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
